gauss_mac_seq: RTL

- Sequential 3x3 Gaussian convolution engine that sits directly downstream of the 8x8 Dadda-tree multiplier.
- Accepts one 3x3 pixel window plus nine kernel coefficients over a valid/ready handshake.
- Time-multiplexes a single external multiplier over the nine taps and accumulates the 16-bit products.
- Rounds, shifts and saturates the sum into one 8-bit filtered pixel, presented on a valid/ready output.

---
 rtl/gauss_pkg.sv | 24 ++
 rtl/gauss_round_sat.sv | 28 ++
 rtl/gauss_mac_seq.sv | 120 ++++++++++++
 3 files changed

// File: rtl/gauss_pkg.sv
// gauss_pkg: shared constants and types for the sequential 3x3 Gaussian
// convolution engine and its round/saturate stage.
//   TAPS      - window taps (3x3)
//   PIX_W     - pixel / coefficient width
//   PROD_W    - multiplier product width
//   ACC_W_DEF - default accumulator width (9*255*255 fits in 20 bits)
//   TAP_W     - tap counter width
//   state_t   - engine FSM states
package gauss_pkg;

  localparam int TAPS      = 9;
  localparam int PIX_W     = 8;
  localparam int PROD_W    = 16;
  localparam int ACC_W_DEF = 20;
  localparam int TAP_W     = 4;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    NORM,
    OUT
  } state_t;

endpackage

// File: rtl/gauss_round_sat.sv
// gauss_round_sat: combinational round-half-up, right shift by SHIFT and
// saturation of an unsigned accumulator down to one 8-bit pixel.
// Ports:
//   acc - unsigned accumulated sum, ACC_W bits
//   pix - rounded, shifted, saturated pixel
module gauss_round_sat
  import gauss_pkg::*;
#(
  parameter int SHIFT = 4,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0] acc,
  output logic [PIX_W-1:0] pix
);

  // Rounding constant is half an output LSB; none when there is no shift.
  localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [ACC_W:0] RND = (SHIFT > 0) ? ((ACC_W + 1)'(1) << RND_POS) : '0;

  logic [ACC_W:0] sum;
  logic [ACC_W:0] shifted;

  // One extra bit so the rounding add can never wrap.
  assign sum     = {1'b0, acc} + RND;
  assign shifted = sum >> SHIFT;
  assign pix     = (|shifted[ACC_W:PIX_W]) ? {PIX_W{1'b1}} : shifted[PIX_W-1:0];

endmodule

// File: rtl/gauss_mac_seq.sv
// gauss_mac_seq: sequential 3x3 convolution. Accepts a pixel window and nine
// coefficients, drives one external multiplier tap by tap for nine cycles,
// accumulates the products, then rounds/shifts/saturates into one pixel.
// Ports:
//   clk, rst_n           - clock (rising edge), asynchronous active-low reset
//   win_valid/win_ready  - window handshake; win_data/coef_data carry 9 taps,
//                          tap k in bits [8k+7:8k], tap 0 top-left, row-major
//   mul_a, mul_b, mul_p  - external multiplier operands and product
//   pix_valid/pix_ready  - output pixel handshake, pix_data is the pixel
//   busy                 - engine is not idle
module gauss_mac_seq
  import gauss_pkg::*;
#(
  parameter int SHIFT = 4,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    win_valid,
  output logic                    win_ready,
  input  logic [TAPS*PIX_W-1:0]   win_data,
  input  logic [TAPS*PIX_W-1:0]   coef_data,
  output logic [PIX_W-1:0]        mul_a,
  output logic [PIX_W-1:0]        mul_b,
  input  logic [PROD_W-1:0]       mul_p,
  output logic                    pix_valid,
  input  logic                    pix_ready,
  output logic [PIX_W-1:0]        pix_data,
  output logic                    busy
);

  state_t             state_reg;
  logic [TAP_W-1:0]   tap_reg;
  logic [ACC_W-1:0]   acc_reg;
  logic [PIX_W-1:0]   win_reg  [TAPS];
  logic [PIX_W-1:0]   coef_reg [TAPS];
  logic [PIX_W-1:0]   win_in   [TAPS];
  logic [PIX_W-1:0]   coef_in  [TAPS];
  logic               pix_valid_reg;
  logic [PIX_W-1:0]   pix_data_reg;
  logic [PIX_W-1:0]   norm_pix;
  logic               accept;

  for (genvar gi = 0; gi < TAPS; gi++) begin : g_unpack
    assign win_in[gi]  = win_data[gi*PIX_W +: PIX_W];
    assign coef_in[gi] = coef_data[gi*PIX_W +: PIX_W];
  end

  // In OUT a new window may be taken on the same edge the pixel leaves.
  assign win_ready = rst_n && ((state_reg == IDLE) || ((state_reg == OUT) && pix_ready));
  assign accept    = win_valid && win_ready;
  assign busy      = (state_reg != IDLE);

  // Operands are forced to zero outside MAC so the multiplier stays quiet.
  assign mul_a = (state_reg == MAC) ? win_reg[tap_reg]  : '0;
  assign mul_b = (state_reg == MAC) ? coef_reg[tap_reg] : '0;

  assign pix_valid = pix_valid_reg;
  assign pix_data  = pix_data_reg;

  gauss_round_sat #(
    .SHIFT (SHIFT),
    .ACC_W (ACC_W)
  ) u_round_sat (
    .acc (acc_reg),
    .pix (norm_pix)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      tap_reg       <= '0;
      acc_reg       <= '0;
      win_reg       <= '{default: '0};
      coef_reg      <= '{default: '0};
      pix_valid_reg <= 1'b0;
      pix_data_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            win_reg   <= win_in;
            coef_reg  <= coef_in;
            acc_reg   <= '0;
            tap_reg   <= '0;
            state_reg <= MAC;
          end
        end
        MAC: begin
          acc_reg <= acc_reg + ACC_W'(mul_p);
          tap_reg <= tap_reg + 1'b1;
          if (tap_reg == TAP_W'(TAPS - 1)) begin
            state_reg <= NORM;
          end
        end
        NORM: begin
          pix_data_reg  <= norm_pix;
          pix_valid_reg <= 1'b1;
          state_reg     <= OUT;
        end
        OUT: begin
          if (pix_ready) begin
            pix_valid_reg <= 1'b0;
            if (accept) begin
              win_reg   <= win_in;
              coef_reg  <= coef_in;
              acc_reg   <= '0;
              tap_reg   <= '0;
              state_reg <= MAC;
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
